eth_status_poller: RTL and testbench
====================================

Name: eth_status_poller

Overview:
- AXI4-Lite master that periodically reads the 32-bit Ethernet PCS-alignment status register (register index 0) of the Ethernet status slave.
- Latches the value, flags changes and bus errors, and drives the board status LEDs from the latched value.
- Sits in the management clock domain next to the status slave; it is the initiating end of that AXI4-Lite link.
- Read-only master: AW/W are held idle.

Parameters:
- POLL_CYCLES, 100000: clk cycles between completion of one read and issue of the next; minimum 1.
- STATUS_ADDR, 32'h0000_0000: byte address placed on M_AXI_ARADDR.
- TIMEOUT_CYCLES, 1024: cycles in ARV/RD before bus_hung asserts (optional feature only).

Ports:
- clk  in  1  clock, all logic rising-edge.
- resetn  in  1  reset, synchronous, active-low.
- enable  in  1  1 = polling permitted.
- status  out  32  last successfully read value.
- status_valid  out  1  sticky; 1 after first OKAY read.
- status_changed  out  1  one-cycle pulse when a new OKAY read differs from status, or on the first OKAY read.
- rd_error  out  1  one-cycle pulse on RRESP != OKAY.
- err_count  out  8  saturating count of error responses.
- bus_hung  out  1  timeout indicator (optional feature).
- led_green_l  out  4  active-low green LEDs.
- led_orange_l  out  4  active-low orange LEDs.
- M_AXI_ARADDR  out  32.
- M_AXI_ARVALID  out  1.
- M_AXI_ARPROT  out  3  constant 0.
- M_AXI_ARREADY  in  1.
- M_AXI_RDATA  in  32.
- M_AXI_RRESP  in  2.
- M_AXI_RVALID  in  1.
- M_AXI_RREADY  out  1.
- M_AXI_AWADDR/AWPROT/WDATA/WSTRB  out  32/3/32/4  constant 0.
- M_AXI_AWVALID, M_AXI_WVALID  out  1  constant 0.
- M_AXI_BREADY  out  1  constant 1.

Behaviour:
- Reset values: ARVALID=0, RREADY=0, status=0, status_valid=0, status_changed=0, rd_error=0, err_count=0, bus_hung=0, wait counter=0, state=WAIT. Reset asserted mid-transaction abandons it immediately; the surrounding system resets the slave with the same resetn.
- State WAIT:
  - counter!=0: decrement each cycle.
  - counter==0 and enable=1: go to ARV, assert ARVALID on the next cycle.
  - The first read therefore issues 1 cycle after reset release, if enable=1.
- State ARV:
  - ARVALID=1 and ARADDR=STATUS_ADDR, held stable until the cycle ARREADY=1.
  - ARVALID is never withdrawn before the handshake, even if enable drops.
  - On handshake: ARVALID=0, RREADY=1, go to RD.
- State RD:
  - RREADY=1 until RVALID=1.
  - On the RVALID&RREADY cycle: RREADY=0, counter loaded with POLL_CYCLES-1, go to WAIT.
  - RRESP==OKAY(0): status<=RDATA and status_valid<=1 next cycle. status_changed pulses in that same cycle if RDATA!=old status or status_valid was 0.
  - RRESP!=OKAY: status unchanged; rd_error pulses 1 cycle; err_count increments, saturating at 255.
- Minimum transaction: ARREADY and RVALID each high on first sight gives 1 cycle in ARV and 1 in RD.
- One outstanding read at most. RVALID seen in WAIT or ARV is ignored (RREADY=0).
- enable=0 never aborts an in-flight read; the block returns to WAIT and holds. The counter keeps decrementing to 0 and stops there; polling resumes the cycle after enable returns.
- LEDs:
  - status_valid=0: led_green_l=4'hF, led_orange_l=4'hF.
  - Otherwise: led_orange_l={2'b11, status[1:0]}; led_green_l={2'b11, ~status[1:0]}.
  - Net effect: green lit = link up, orange lit = link down.

Optional Feature:
- Macro: ETH_POLLER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while in ARV or RD and clears on state entry.
  - On reaching TIMEOUT_CYCLES it sets bus_hung=1. The transaction is not abandoned, to preserve AXI rules.
  - bus_hung clears on the cycle the pending handshake completes.
- Undefined: bus_hung tied to 0; no timeout counter is synthesised.

Test Plan:
- Reset release, enable=1, POLL_CYCLES=8, slave returns RDATA=32'h3 OKAY:
  - ARVALID rises 1 cycle after reset with ARADDR=0.
  - status=3, status_valid=1, status_changed pulses once.
  - led_green_l=4'hC, led_orange_l=4'hF.
  - Next ARVALID rises 8 cycles after the R handshake.
- Slave delays ARREADY 5 cycles and RVALID 7 cycles: ARVALID and ARADDR are stable throughout; RREADY is 0 until the AR handshake; exactly one read completes.
- Consecutive reads return 3, 3, 1: status_changed pulses on the 1st and 3rd only; final led_green_l=4'hE, led_orange_l=4'hD.
- Slave returns RRESP=2'b11 with RDATA=32'hFFFF_FFFF after a good value 3: status stays 3; rd_error pulses once; err_count=1. After 300 such errors, err_count=255.
- enable dropped during RD, then raised 50 cycles later (POLL_CYCLES=8): the read completes normally; no new ARVALID while enable=0; ARVALID rises 1 cycle after enable returns.
- ETH_POLLER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, slave never asserts RVALID: bus_hung=1 after 16 cycles in RD; RVALID then asserted causes bus_hung=0 and status to update. With the macro undefined, bus_hung stays 0.

Source files
------------

// File: rtl/eth_status_poller_if.sv
// AXI4-Lite read link between eth_status_poller (master) and the Ethernet status slave.
// Only the AR/R channels carry traffic; AW/W/B are present so the slave sees a complete port.
interface eth_status_poller_if;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;
  logic [31:0] M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_BREADY;

  modport master (
    output M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARPROT, M_AXI_RREADY,
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARPROT, M_AXI_RREADY,
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
endinterface

// File: rtl/eth_status_poller.sv
// Periodic AXI4-Lite reader of the Ethernet PCS-alignment status register; drives status LEDs.
// Optional bus-hang detection is built when ETH_POLLER_TIMEOUT_EN is defined.
module eth_status_poller #(
  parameter int unsigned POLL_CYCLES    = 100000,
  parameter logic [31:0] STATUS_ADDR    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  output logic [31:0] status,
  output logic        status_valid,
  output logic        status_changed,
  output logic        rd_error,
  output logic [7:0]  err_count,
  output logic        bus_hung,
  output logic [3:0]  led_green_l,
  output logic [3:0]  led_orange_l,
  eth_status_poller_if.master axi
);

  typedef enum logic [1:0] {WAIT, ARV, RD} state_t;

  state_t      state;
  logic [31:0] wait_cnt;
  logic        arvalid;
  logic        rready;

  assign axi.M_AXI_ARADDR  = STATUS_ADDR;
  assign axi.M_AXI_ARVALID = arvalid;
  assign axi.M_AXI_ARPROT  = 3'b000;
  assign axi.M_AXI_RREADY  = rready;
  assign axi.M_AXI_AWADDR  = 32'h0;
  assign axi.M_AXI_AWPROT  = 3'b000;
  assign axi.M_AXI_AWVALID = 1'b0;
  assign axi.M_AXI_WDATA   = 32'h0;
  assign axi.M_AXI_WSTRB   = 4'h0;
  assign axi.M_AXI_WVALID  = 1'b0;
  assign axi.M_AXI_BREADY  = 1'b1;

  // Bits [1:0] are the per-lane alignment flags: green lit when aligned, orange when not.
  assign led_green_l  = status_valid ? {2'b11, ~status[1:0]} : 4'hF;
  assign led_orange_l = status_valid ? {2'b11,  status[1:0]} : 4'hF;

`ifdef ETH_POLLER_TIMEOUT_EN
  logic [31:0] hung_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign bus_hung       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= WAIT;
      wait_cnt       <= 32'd0;
      arvalid        <= 1'b0;
      rready         <= 1'b0;
      status         <= 32'd0;
      status_valid   <= 1'b0;
      status_changed <= 1'b0;
      rd_error       <= 1'b0;
      err_count      <= 8'd0;
`ifdef ETH_POLLER_TIMEOUT_EN
      hung_cnt       <= 32'd0;
      bus_hung       <= 1'b0;
`endif
    end else begin
      status_changed <= 1'b0;
      rd_error       <= 1'b0;
      case (state)
        WAIT: begin
          if (wait_cnt != 32'd0) begin
            wait_cnt <= wait_cnt - 32'd1;
          end else if (enable) begin
            state   <= ARV;
            arvalid <= 1'b1;
          end
        end
        // Once ARVALID is up it stays up until accepted, whatever enable does.
        ARV: begin
          if (axi.M_AXI_ARREADY) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD;
          end
        end
        RD: begin
          if (axi.M_AXI_RVALID) begin
            rready   <= 1'b0;
            wait_cnt <= POLL_CYCLES - 32'd1;
            state    <= WAIT;
            if (axi.M_AXI_RRESP == 2'b00) begin
              status         <= axi.M_AXI_RDATA;
              status_valid   <= 1'b1;
              status_changed <= (axi.M_AXI_RDATA != status) || !status_valid;
            end else begin
              rd_error <= 1'b1;
              if (err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            end
          end
        end
        default: state <= WAIT;
      endcase
`ifdef ETH_POLLER_TIMEOUT_EN
      // The stalled transaction is only flagged, never abandoned, so the AXI handshake stays legal.
      if (state == WAIT || (state == ARV && axi.M_AXI_ARREADY) ||
          (state == RD && axi.M_AXI_RVALID)) begin
        hung_cnt <= 32'd0;
        bus_hung <= 1'b0;
      end else if (!bus_hung) begin
        hung_cnt <= hung_cnt + 32'd1;
        if (hung_cnt == TIMEOUT_CYCLES - 32'd1)
          bus_hung <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_eth_status_poller.sv
// Randomized self-checking bench for eth_status_poller; a behavioural slave answers each read
// and a small model of the status/error rules predicts every observable result.
module tb_eth_status_poller;

  localparam int unsigned TB_POLL    = 8;
  localparam int unsigned TB_TIMEOUT = 16;
  localparam int WAIT_LIMIT = 2000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [31:0] status;
  logic        status_valid, status_changed, rd_error, bus_hung;
  logic [7:0]  err_count;
  logic [3:0]  led_green_l, led_orange_l;

  eth_status_poller_if bus ();

  eth_status_poller #(
    .POLL_CYCLES   (TB_POLL),
    .STATUS_ADDR   (32'h0000_0000),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .status        (status),
    .status_valid  (status_valid),
    .status_changed(status_changed),
    .rd_error      (rd_error),
    .err_count     (err_count),
    .bus_hung      (bus_hung),
    .led_green_l   (led_green_l),
    .led_orange_l  (led_orange_l),
    .axi           (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: last good value, whether one was ever seen, saturating error tally.
  logic [31:0] exp_status;
  bit          exp_valid;
  int          exp_err;

  typedef struct {
    bit          ok;
    int          waited;
    int          hung_first;
    logic [31:0] status;
    logic        valid, changed, err, hung, late_pulse;
    logic [7:0]  errc;
    logic [3:0]  green, orange;
  } obs_t;

  function automatic void model_read(input logic [31:0] data, input logic [1:0] resp,
                                     output bit chg, output bit err);
    chg = 1'b0;
    err = 1'b0;
    if (resp == 2'b00) begin
      chg        = !exp_valid || (data != exp_status);
      exp_status = data;
      exp_valid  = 1'b1;
    end else begin
      err = 1'b1;
      if (exp_err < 255) exp_err++;
    end
  endfunction

  // Returns {green_l, orange_l}: each aligned lane lights green, each misaligned lane orange.
  function automatic logic [7:0] model_leds();
    logic [3:0] g = 4'hF;
    logic [3:0] o = 4'hF;
    if (exp_valid)
      for (int i = 0; i < 2; i++)
        if (exp_status[i]) g[i] = 1'b0; else o[i] = 1'b0;
    return {g, o};
  endfunction

  // Slave side of one read. waited counts negedges until ARVALID is seen; the call consumes one
  // negedge after the R handshake, so back-to-back polls see waited = POLL - 1.
  task automatic applyStimulus(input int ar_delay, input int r_delay, input logic [31:0] data,
                               input logic [1:0] resp, input bit drop_en, output obs_t o);
    o.ok = 1'b1;
    o.waited = 0;
    o.hung_first = -1;
    while (bus.M_AXI_ARVALID !== 1'b1 && o.waited < WAIT_LIMIT) begin
      @(negedge clk);
      o.waited++;
    end
    if (bus.M_AXI_ARVALID !== 1'b1) begin
      o.ok = 1'b0;
      return;
    end
    for (int i = 0; i <= ar_delay; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.M_AXI_ARVALID !== 1'b1 || bus.M_AXI_ARADDR !== 32'h0 || bus.M_AXI_RREADY !== 1'b0)
        o.ok = 1'b0;
    end
    bus.M_AXI_ARREADY = 1'b1;
    @(negedge clk);
    bus.M_AXI_ARREADY = 1'b0;
    if (drop_en) enable = 1'b0;
    for (int i = 0; i <= r_delay; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.M_AXI_ARVALID !== 1'b0 || bus.M_AXI_RREADY !== 1'b1) o.ok = 1'b0;
      if (bus_hung === 1'b1 && o.hung_first < 0) o.hung_first = i;
    end
    bus.M_AXI_RVALID = 1'b1;
    bus.M_AXI_RDATA  = data;
    bus.M_AXI_RRESP  = resp;
    @(negedge clk);
    bus.M_AXI_RVALID = 1'b0;
    bus.M_AXI_RDATA  = $urandom;
    bus.M_AXI_RRESP  = 2'($urandom);
    if (bus.M_AXI_RREADY !== 1'b0) o.ok = 1'b0;
    o.status  = status;
    o.valid   = status_valid;
    o.changed = status_changed;
    o.err     = rd_error;
    o.errc    = err_count;
    o.hung    = bus_hung;
    o.green   = led_green_l;
    o.orange  = led_orange_l;
    @(negedge clk);
    o.late_pulse = status_changed | rd_error;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    enable = 1'b0;
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RVALID  = 1'b0;
    bus.M_AXI_RDATA   = 32'h0;
    bus.M_AXI_RRESP   = 2'b00;
    repeat (3) @(negedge clk);
    total++; if (bus.M_AXI_ARVALID !== 1'b0 || bus.M_AXI_RREADY !== 1'b0) begin bad++;
      $display("[TB] FAIL reset_handshake: got arvalid=%b rready=%b want 0 0", bus.M_AXI_ARVALID, bus.M_AXI_RREADY); end
    total++; if ({status, status_valid, status_changed, rd_error, err_count, bus_hung} !== 44'h0) begin bad++;
      $display("[TB] FAIL reset_outputs: got status=%h valid=%b chg=%b err=%b cnt=%0d hung=%b want all 0",
               status, status_valid, status_changed, rd_error, err_count, bus_hung); end
    total++; if ({led_green_l, led_orange_l} !== 8'hFF) begin bad++;
      $display("[TB] FAIL reset_leds: got %h want ff", {led_green_l, led_orange_l}); end
    total++; if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARPROT} !== 6'b001000) begin bad++;
      $display("[TB] FAIL idle_channels: got awv=%b wv=%b bready=%b arprot=%b want 0 0 1 000",
               bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARPROT); end
    exp_status = 32'h0;
    exp_valid  = 1'b0;
    exp_err    = 0;
    enable = 1'b1;
    resetn = 1'b1;
  endtask

  task automatic test_first_read();
    obs_t o;
    bit chg, err;
    applyStimulus(0, 0, 32'h3, 2'b00, 1'b0, o);
    model_read(32'h3, 2'b00, chg, err);
    total++; if (!o.ok || o.waited != 1) begin bad++;
      $display("[TB] FAIL first_issue: got ok=%b waited=%0d want ok=1 waited=1", o.ok, o.waited); end
    total++; if (o.status !== exp_status || o.valid !== 1'b1) begin bad++;
      $display("[TB] FAIL first_status: got %h/%b want %h/1", o.status, o.valid, exp_status); end
    total++; if (o.changed !== chg || o.late_pulse !== 1'b0) begin bad++;
      $display("[TB] FAIL first_changed: got %b then %b want %b then 0", o.changed, o.late_pulse, chg); end
    total++; if ({o.green, o.orange} !== model_leds()) begin bad++;
      $display("[TB] FAIL first_leds: got %h want %h", {o.green, o.orange}, model_leds()); end
  endtask

  task automatic test_change_detect();
    obs_t o;
    bit chg, err;
    logic [31:0] seq [2] = '{32'h3, 32'h1};
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, seq[k], 2'b00, 1'b0, o);
      model_read(seq[k], 2'b00, chg, err);
      total++; if (!o.ok || o.waited != int'(TB_POLL) - 1) begin bad++;
        $display("[TB] FAIL poll_interval: got ok=%b waited=%0d want ok=1 waited=%0d", o.ok, o.waited, TB_POLL - 1); end
      total++; if (o.changed !== chg || o.status !== exp_status) begin bad++;
        $display("[TB] FAIL change_%0d: got chg=%b status=%h want chg=%b status=%h", k, o.changed, o.status, chg, exp_status); end
    end
    total++; if ({o.green, o.orange} !== 8'hED) begin bad++;
      $display("[TB] FAIL link_down_leds: got %h want ed", {o.green, o.orange}); end
  endtask

  task automatic test_stall();
    obs_t o;
    bit chg, err;
    logic [31:0] d = $urandom;
    applyStimulus(5, 7, d, 2'b00, 1'b0, o);
    model_read(d, 2'b00, chg, err);
    total++; if (!o.ok) begin bad++;
      $display("[TB] FAIL stall_protocol: got ok=%b want 1", o.ok); end
    total++; if (o.status !== exp_status || o.changed !== chg || o.late_pulse !== 1'b0) begin bad++;
      $display("[TB] FAIL stall_result: got %h chg=%b late=%b want %h chg=%b late=0", o.status, o.changed, o.late_pulse, exp_status, chg); end
  endtask

  task automatic test_random();
    obs_t o;
    bit chg, err;
    logic [31:0] d;
    logic [1:0]  r;
    for (int n = 0; n < 25; n++) begin
      d = ($urandom_range(0, 2) == 0) ? exp_status : $urandom;
      r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      applyStimulus(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), d, r, 1'b0, o);
      model_read(d, r, chg, err);
      total++; if (!o.ok || o.waited != int'(TB_POLL) - 1) begin bad++;
        $display("[TB] FAIL rand_%0d_protocol: got ok=%b waited=%0d want 1 %0d", n, o.ok, o.waited, TB_POLL - 1); end
      total++; if (o.status !== exp_status || o.changed !== chg || o.err !== err || o.errc !== 8'(exp_err)) begin bad++;
        $display("[TB] FAIL rand_%0d_result: got %h chg=%b err=%b cnt=%0d want %h chg=%b err=%b cnt=%0d",
                 n, o.status, o.changed, o.err, o.errc, exp_status, chg, err, exp_err); end
      total++; if ({o.green, o.orange} !== model_leds() || o.late_pulse !== 1'b0) begin bad++;
        $display("[TB] FAIL rand_%0d_leds: got %h late=%b want %h late=0", n, {o.green, o.orange}, o.late_pulse, model_leds()); end
      if (!o.ok) break;
    end
  endtask

  task automatic test_enable_drop();
    obs_t o;
    bit chg, err, early;
    logic [31:0] d = $urandom;
    applyStimulus(1, 3, d, 2'b00, 1'b1, o);
    model_read(d, 2'b00, chg, err);
    total++; if (!o.ok || o.status !== exp_status) begin bad++;
      $display("[TB] FAIL disable_inflight: got ok=%b status=%h want ok=1 status=%h", o.ok, o.status, exp_status); end
    early = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (bus.M_AXI_ARVALID !== 1'b0) early = 1'b1;
    end
    total++; if (early) begin bad++;
      $display("[TB] FAIL disabled_idle: got arvalid while enable=0 want none"); end
    enable = 1'b1;
    d = $urandom;
    applyStimulus(0, 0, d, 2'b00, 1'b0, o);
    model_read(d, 2'b00, chg, err);
    total++; if (!o.ok || o.waited != 1 || o.status !== exp_status) begin bad++;
      $display("[TB] FAIL resume: got ok=%b waited=%0d status=%h want ok=1 waited=1 status=%h", o.ok, o.waited, o.status, exp_status); end
  endtask

  task automatic test_timeout();
    obs_t o;
    bit chg, err;
    logic [31:0] d = $urandom;
`ifdef ETH_POLLER_TIMEOUT_EN
    applyStimulus(0, 20, d, 2'b00, 1'b0, o);
    model_read(d, 2'b00, chg, err);
    total++; if (o.hung_first != int'(TB_TIMEOUT)) begin bad++;
      $display("[TB] FAIL hung_rise: got cycle %0d want %0d", o.hung_first, TB_TIMEOUT); end
    total++; if (o.hung !== 1'b0 || o.status !== exp_status) begin bad++;
      $display("[TB] FAIL hung_clear: got hung=%b status=%h want 0 %h", o.hung, o.status, exp_status); end
`else
    applyStimulus(0, 40, d, 2'b00, 1'b0, o);
    model_read(d, 2'b00, chg, err);
    total++; if (o.hung_first != -1 || o.hung !== 1'b0) begin bad++;
      $display("[TB] FAIL hung_tied: got first=%0d hung=%b want -1 0", o.hung_first, o.hung); end
`endif
    total++; if (!o.ok) begin bad++;
      $display("[TB] FAIL long_read: got ok=%b want 1", o.ok); end
  endtask

  task automatic test_errors();
    obs_t o;
    bit chg, err;
    applyStimulus(0, 0, 32'h3, 2'b00, 1'b0, o);
    model_read(32'h3, 2'b00, chg, err);
    applyStimulus(0, 0, 32'hFFFF_FFFF, 2'b11, 1'b0, o);
    model_read(32'hFFFF_FFFF, 2'b11, chg, err);
    total++; if (o.status !== 32'h3 || o.err !== 1'b1 || o.late_pulse !== 1'b0 || o.errc !== 8'(exp_err)) begin bad++;
      $display("[TB] FAIL slverr: got %h err=%b late=%b cnt=%0d want 3 1 0 %0d", o.status, o.err, o.late_pulse, o.errc, exp_err); end
    for (int n = 0; n < 300; n++) begin
      applyStimulus(0, int'($urandom_range(0, 1)), $urandom, 2'($urandom_range(1, 3)), 1'b0, o);
      model_read(32'h0, 2'b11, chg, err);
      if (!o.ok) break;
    end
    total++; if (o.errc !== 8'd255 || o.status !== 32'h3 || o.valid !== 1'b1) begin bad++;
      $display("[TB] FAIL err_saturate: got cnt=%0d status=%h valid=%b want 255 3 1", o.errc, o.status, o.valid); end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_first_read();
    test_change_detect();
    test_stall();
    test_random();
    test_enable_drop();
    test_timeout();
    test_errors();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
